// File: rtl/img_seq_pkg.sv
// Shared types and default geometry for the image frame sequencer.
// Contents: FSM state enum, default parameter constants, counter-width helper.
// Pure declarations; no logic.
package img_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        ACTIVE = 3'd2,
        BLANK  = 3'd3,
        TRAIL  = 3'd4
    } seq_state_t;

    localparam int DEF_IMG_HDISP = 512;
    localparam int DEF_IMG_VDISP = 512;
    localparam int DEF_VS_LEAD   = 5;
    localparam int DEF_H_BLANK   = 10;
    localparam int DEF_VS_TRAIL  = 1;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img_frame_sequencer_if.sv
// Memory read bus plus pixel stream towards the sharpen/filter datapath.
// master: sequencer (drives read request and video); slave: memory/consumer.
// No flow control: the stream is free-running once a frame has started.
interface img_frame_sequencer_if #(
    parameter int ADDR_W = 18
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              per_img_vsync;
    logic              per_img_href;
    logic [7:0]        per_img_gray;

    modport master (
        output mem_rd_en, mem_rd_addr, per_img_vsync, per_img_href, per_img_gray,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, per_img_vsync, per_img_href, per_img_gray,
        output mem_rd_data
    );
endinterface

// File: rtl/img_seq_out_pipe.sv
// Aligns read data with a 2-cycle delayed href; gray forced to 0 outside href.
// Latency: rd_en -> href 2 cycles; rd_data (valid 1 cycle after rd_en) -> gray 1 cycle.
// No backpressure; clr empties both stages synchronously.
module img_seq_out_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       rd_en,
    input  logic [7:0] rd_data,
    output logic       href,
    output logic [7:0] gray
);
    logic en_d1;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            en_d1 <= 1'b0;
            href  <= 1'b0;
            gray  <= 8'd0;
        end else begin
            en_d1 <= rd_en;
            href  <= en_d1;
            gray  <= en_d1 ? rd_data : 8'd0;
        end
    end
endmodule

// File: rtl/img_frame_sequencer.sv
// Reads one frame from memory in raster order and emits vsync/href/gray video timing.
// Latency: start -> vsync 1 cycle, -> first rd_en 1+VS_LEAD, rd_en -> href 2 cycles.
// No backpressure; start ignored while busy, abort returns to IDLE without done.
// Ports: clk, rst_n (sync, active-low), start, abort, busy, done, bus (mem read + video).
module img_frame_sequencer
    import img_seq_pkg::*;
#(
    parameter int IMG_HDISP = DEF_IMG_HDISP,
    parameter int IMG_VDISP = DEF_IMG_VDISP,
    parameter int VS_LEAD   = DEF_VS_LEAD,   // assumed >= 1
    parameter int H_BLANK   = DEF_H_BLANK,
    parameter int VS_TRAIL  = DEF_VS_TRAIL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    img_frame_sequencer_if.master bus
);
    localparam int ADDR_W = cnt_w(IMG_HDISP * IMG_VDISP);
    localparam int COL_W  = cnt_w(IMG_HDISP);
    localparam int ROW_W  = cnt_w(IMG_VDISP);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_HDISP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_VDISP - 1);
    localparam logic [15:0]      LEAD_LAST = 16'(VS_LEAD - 1);
    localparam logic [15:0]      BLNK_LAST = 16'(H_BLANK - 1);
    // TRAIL spans the 2-cycle pipe drain plus VS_TRAIL cycles after href falls.
    localparam logic [15:0]      TRL_LAST  = 16'(VS_TRAIL + 1);

    seq_state_t        state;
    logic [15:0]       cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              vsync;
    logic              pipe_clr;
    logic              href_w;
    logic [7:0]        gray_w;

    assign pipe_clr = abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n || pipe_clr) begin
            state <= IDLE;
            cnt   <= 16'd0;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
            rd_en <= 1'b0;
            vsync <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LEAD;
                        vsync <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= 16'd0;
                    end
                end
                LEAD: begin
                    if (cnt == LEAD_LAST) begin
                        state <= ACTIVE;
                        rd_en <= 1'b1;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ACTIVE: begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            row   <= '0;
                            addr  <= '0;
                            rd_en <= 1'b0;
                            state <= TRAIL;
                            cnt   <= 16'd0;
                        end else begin
                            row  <= row + 1'b1;
                            addr <= addr + 1'b1;
                            // With zero blanking the next row follows immediately.
                            if (H_BLANK != 0) begin
                                rd_en <= 1'b0;
                                state <= BLANK;
                                cnt   <= 16'd0;
                            end
                        end
                    end else begin
                        col  <= col + 1'b1;
                        addr <= addr + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLNK_LAST) begin
                        state <= ACTIVE;
                        rd_en <= 1'b1;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                TRAIL: begin
                    if (cnt == TRL_LAST) begin
                        state <= IDLE;
                        vsync <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    img_seq_out_pipe u_out_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (pipe_clr),
        .rd_en   (rd_en),
        .rd_data (bus.mem_rd_data),
        .href    (href_w),
        .gray    (gray_w)
    );

    assign bus.mem_rd_en     = rd_en;
    assign bus.mem_rd_addr   = addr;
    assign bus.per_img_vsync = vsync;
    assign bus.per_img_href  = href_w;
    assign bus.per_img_gray  = gray_w;
endmodule

// File: tb/tb_img_frame_sequencer.sv
// Directed bench for img_frame_sequencer at 4x3, VS_LEAD=2, H_BLANK=3, VS_TRAIL=1.
// Each scenario drives a per-cycle stimulus table, records outputs, then checks.
// Memory model returns 8'hA0+addr one cycle after mem_rd_en.
module tb_img_frame_sequencer;
    localparam int HD = 4;
    localparam int VD = 3;
    localparam int NPIX = HD * VD;
    localparam int AW = 4;
    localparam int NC = 80;

    logic clk;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;
    logic done;

    img_frame_sequencer_if #(.ADDR_W(AW)) bus_if ();

    img_frame_sequencer #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .VS_LEAD   (2),
        .H_BLANK   (3),
        .VS_TRAIL  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:15];
    always @(posedge clk) begin
        if (!rst_n)
            bus_if.mem_rd_data <= 8'd0;
        else if (bus_if.mem_rd_en)
            bus_if.mem_rd_data <= mem[bus_if.mem_rd_addr];
    end

    int n_chk;
    int n_fail;

    bit        st_v [0:NC-1];
    bit        ab_v [0:NC-1];
    bit        rs_v [0:NC-1];
    logic      o_vs [0:NC-1];
    logic      o_hr [0:NC-1];
    logic      o_re [0:NC-1];
    logic      o_bz [0:NC-1];
    logic      o_dn [0:NC-1];
    logic [7:0]    o_gr [0:NC-1];
    logic [AW-1:0] o_ad [0:NC-1];

    int n_href, n_done, done_cyc, gray_bad, gray_nz, addr_bad, gap34, gap78;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stim();
        for (int i = 0; i < NC; i++) begin
            st_v[i] = 1'b0;
            ab_v[i] = 1'b0;
            rs_v[i] = 1'b0;
        end
    endtask

    // Sample cycle c, then apply stimulus for cycle c and advance one clock.
    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            o_vs[c] = bus_if.per_img_vsync;
            o_hr[c] = bus_if.per_img_href;
            o_gr[c] = bus_if.per_img_gray;
            o_re[c] = bus_if.mem_rd_en;
            o_ad[c] = bus_if.mem_rd_addr;
            o_bz[c] = busy;
            o_dn[c] = done;
            start = st_v[c];
            abort = ab_v[c];
            rst_n = !rs_v[c];
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        clr_stim();
    endtask

    task automatic analyze(input int n);
        int idx;
        int cyc_of [0:15];
        logic [7:0] expg;
        for (int a = 0; a < 16; a++) cyc_of[a] = -100;
        idx = 0;
        n_href = 0; n_done = 0; done_cyc = -1;
        gray_bad = 0; gray_nz = 0; addr_bad = 0;
        for (int c = 0; c < n; c++) begin
            if (o_hr[c]) begin
                expg = 8'hA0 + 8'(idx % NPIX);
                if (o_gr[c] !== expg) gray_bad++;
                idx++;
                n_href++;
            end else if (o_gr[c] !== 8'd0) begin
                gray_nz++;
            end
            if (o_dn[c]) begin
                if (done_cyc < 0) done_cyc = c;
                n_done++;
            end
            if (o_re[c]) begin
                if (int'(o_ad[c]) > NPIX - 1) addr_bad++;
                else cyc_of[o_ad[c]] = c;
            end
        end
        gap34 = cyc_of[4] - cyc_of[3] - 1;
        gap78 = cyc_of[8] - cyc_of[7] - 1;
    endtask

    initial begin
        int vlow;
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        clr_stim();
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // start while in reset must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vsync", bus_if.per_img_vsync, 0);
        check("rst_href", bus_if.per_img_href, 0);
        check("rst_gray", bus_if.per_img_gray, 0);
        check("rst_rd_en", bus_if.mem_rd_en, 0);
        check("rst_addr", bus_if.mem_rd_addr, 0);

        // Basic frame: start at cycle 0
        st_v[0] = 1'b1;
        capture(30);
        analyze(30);
        check("f1_vsync0", o_vs[0], 0);
        check("f1_vsync1", o_vs[1], 1);
        check("f1_busy1", o_bz[1], 1);
        check("f1_rden2", o_re[2], 0);
        check("f1_rden3", o_re[3], 1);
        check("f1_addr3", o_ad[3], 0);
        check("f1_href4", o_hr[4], 0);
        check("f1_href5", o_hr[5], 1);
        check("f1_gray5", o_gr[5], 8'hA0);
        check("f1_nhref", n_href, 12);
        check("f1_ndone", n_done, 1);
        check("f1_donecyc", done_cyc, 24);
        check("f1_vsync23", o_vs[23], 1);
        check("f1_vsync24", o_vs[24], 0);
        check("f1_busy24", o_bz[24], 0);
        check("f1_graybad", gray_bad, 0);
        check("f1_graynz", gray_nz, 0);
        check("f1_addrbad", addr_bad, 0);
        check("f1_gap34", gap34, 3);
        check("f1_gap78", gap78, 3);

        // Abort at row 1 col 2 (cycle 12)
        st_v[0] = 1'b1;
        ab_v[12] = 1'b1;
        capture(30);
        analyze(30);
        check("ab_pre_addr", o_ad[12], 6);
        check("ab_pre_href", o_hr[12], 1);
        check("ab_vsync", o_vs[13], 0);
        check("ab_href", o_hr[13], 0);
        check("ab_gray", o_gr[13], 0);
        check("ab_rden", o_re[13], 0);
        check("ab_busy", o_bz[13], 0);
        check("ab_ndone", n_done, 0);
        check("ab_nhref", n_href, 5);
        check("ab_graybad", gray_bad, 0);

        // Full frame after abort
        st_v[0] = 1'b1;
        capture(30);
        analyze(30);
        check("ar_nhref", n_href, 12);
        check("ar_ndone", n_done, 1);
        check("ar_graybad", gray_bad, 0);

        // start during BLANK (cycle 8) is ignored
        st_v[0] = 1'b1;
        st_v[8] = 1'b1;
        capture(40);
        analyze(40);
        check("bl_nhref", n_href, 12);
        check("bl_ndone", n_done, 1);
        check("bl_donecyc", done_cyc, 24);
        check("bl_gap34", gap34, 3);
        check("bl_vsync26", o_vs[26], 0);

        // Back-to-back: start again in the done cycle
        st_v[0] = 1'b1;
        st_v[24] = 1'b1;
        capture(55);
        analyze(55);
        vlow = 0;
        for (int c = 1; c < 48; c++) if (!o_vs[c]) vlow++;
        check("bb_done24", o_dn[24], 1);
        check("bb_vsync25", o_vs[25], 1);
        check("bb_vlow", vlow, 1);
        check("bb_nhref", n_href, 24);
        check("bb_ndone", n_done, 2);
        check("bb_done48", o_dn[48], 1);
        check("bb_graybad", gray_bad, 0);

        // Reset mid-frame with coincident start
        st_v[0] = 1'b1;
        rs_v[12] = 1'b1;
        st_v[12] = 1'b1;
        capture(20);
        check("mr_pre_busy", o_bz[12], 1);
        check("mr_vsync", o_vs[13], 0);
        check("mr_href", o_hr[13], 0);
        check("mr_gray", o_gr[13], 0);
        check("mr_rden", o_re[13], 0);
        check("mr_addr", o_ad[13], 0);
        check("mr_busy13", o_bz[13], 0);
        check("mr_busy14", o_bz[14], 0);
        check("mr_vsync14", o_vs[14], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
